// File: rtl/display_scan.sv
// display_scan
//
// Time-multiplexes a double-buffered 4-digit hex value onto shared 7-segment
// lines and per-digit anodes. Every rising edge of the clk_display strobe
// advances to the next digit. Before each digit is driven, the anodes are held
// off for BLANK_CYCLES clk cycles so the previous digit does not ghost.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-low
//   clk_display  square-wave strobe from the divider, synchronous to clk
//   value[15:0]  four hex digits; digit 0 is value[3:0] (rightmost)
//   load         single-cycle request to capture value into staging
//   blank_lz     leading-zero blanking enable (used live while driving)
//   seg[6:0]     segment lines {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   an[3:0]      digit enables, an[i] = digit i, polarity set by AN_ACTIVE_LOW
//   frame_done   one-cycle pulse on the step where the index wraps 3 -> 0
//   state_dbg    current FSM state (0 IDLE, 1 BLANK, 2 DRIVE)
//
// Handshake: there is no valid/ready pair. A step is the single clk cycle in
// which clk_display=1 and its registered copy is 0. load is sampled on every
// clk edge with no back-pressure; the last load before a wrap wins.
module display_scan #(
    parameter int BLANK_CYCLES   = 27,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_display,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0] AN_OFF     = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;
    localparam logic [9:0] BLANK_LAST = 10'(BLANK_CYCLES - 1);

    state_t      state;
    logic        prev;
    logic [1:0]  index;
    logic [9:0]  blank_cnt;
    logic [15:0] staging;
    logic [15:0] shadow;

    logic        step;
    logic [3:0]  digit;
    logic        lz;
    logic [6:0]  seg_hi;
    logic [3:0]  an_hi;
    logic [6:0]  seg_drive;
    logic [3:0]  an_drive;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign step      = clk_display & ~prev;
    assign state_dbg = state;

    // Active-high pattern for the digit currently selected by index.
    always_comb begin
        digit = 4'h0;
        lz    = 1'b0;
        case (index)
            2'd0: begin digit = shadow[3:0];   lz = 1'b0;                   end
            2'd1: begin digit = shadow[7:4];   lz = (shadow[15:4]  == 12'h0); end
            2'd2: begin digit = shadow[11:8];  lz = (shadow[15:8]  == 8'h0);  end
            default: begin digit = shadow[15:12]; lz = (shadow[15:12] == 4'h0); end
        endcase
        seg_hi    = (blank_lz && lz) ? 7'h00 : decode(digit);
        an_hi     = 4'b0001 << index;
        seg_drive = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
        an_drive  = AN_ACTIVE_LOW  ? ~an_hi  : an_hi;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            prev       <= 1'b0;
            index      <= 2'd0;
            blank_cnt  <= 10'd0;
            staging    <= 16'h0;
            shadow     <= 16'h0;
            frame_done <= 1'b0;
            seg        <= SEG_OFF;
            an         <= AN_OFF;
        end else begin
            prev       <= clk_display;
            frame_done <= 1'b0;
            if (load) staging <= value;

            case (state)
                IDLE: begin
                    seg <= SEG_OFF;
                    an  <= AN_OFF;
                    if (step) begin
                        state     <= BLANK;
                        blank_cnt <= 10'd0;
                    end
                end
                BLANK, DRIVE: begin
                    if (step) begin
                        state     <= BLANK;
                        index     <= index + 2'd1;
                        blank_cnt <= 10'd0;
                        seg       <= SEG_OFF;
                        an        <= AN_OFF;
                        if (index == 2'd3) begin
                            // Frame boundary: a load on this very step bypasses staging.
                            frame_done <= 1'b1;
                            shadow     <= load ? value : staging;
                        end
                    end else if (state == BLANK) begin
                        if (blank_cnt == BLANK_LAST) begin
                            state <= DRIVE;
                            seg   <= seg_drive;
                            an    <= an_drive;
                        end else begin
                            blank_cnt <= blank_cnt + 10'd1;
                            seg       <= SEG_OFF;
                            an        <= AN_OFF;
                        end
                    end else begin
                        // Refresh every cycle so blank_lz takes effect while lit.
                        seg <= seg_drive;
                        an  <= an_drive;
                    end
                end
                default: begin
                    state <= IDLE;
                    seg   <= SEG_OFF;
                    an    <= AN_OFF;
                end
            endcase
        end
    end

endmodule
